sc_fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the single-cycle processor controller. It owns the PC register and issues word reads to instruction memory over a valid/ready request plus valid response handshake. It presents a stable iword to the controller and decoder. On retire it computes the next PC from the controller's PCSel, the decoded immediate and the JAL base register value.

---
 rtl/sc_proc_pkg.sv | 31 +++
 rtl/sc_next_pc.sv | 31 +++
 rtl/sc_fetch_unit.sv | 128 ++++++++++++
 tb/tb_sc_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_proc_pkg.sv
// Shared definitions for the single-cycle processor: next-PC select encoding,
// controller opcodes and the fetch FSM states (FAULT exists only with FETCH_ALIGN_CHECK_EN).
package sc_proc_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JAL = 2'd2;

  localparam logic [5:0] OPC_ALU    = 6'h00;
  localparam logic [5:0] OPC_ALUI   = 6'h01;
  localparam logic [5:0] OPC_LOAD   = 6'h02;
  localparam logic [5:0] OPC_STORE  = 6'h03;
  localparam logic [5:0] OPC_BRANCH = 6'h04;
  localparam logic [5:0] OPC_JAL    = 6'h05;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_ISSUE = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_ISSUE = 2'd2
  } fetch_state_e;
`endif

endpackage

// File: rtl/sc_next_pc.sv
// Combinational next-PC computation: sign-extended, word-scaled immediate
// applied to pc+4 (branch) or to the JAL base register; reserved select acts as sequential.
module sc_next_pc
  import sc_proc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_sel,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] jal_base,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] ext;
  logic [ADDR_W-1:0] off;

  always_comb begin
    ext      = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    off      = ext << 2;
    pc_plus4 = pc + ADDR_W'(4);
    case (pc_sel)
      PC_SEL_BR:  next_pc = pc_plus4 + off;
      PC_SEL_JAL: next_pc = jal_base + off;
      default:    next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/sc_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and holds iword
// until retire. Optional misaligned-target trap enabled by FETCH_ALIGN_CHECK_EN.
module sc_fetch_unit
  import sc_proc_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                IMM_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic [31:0]       iword,
  output logic              iword_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              retire,
  input  logic [1:0]        pc_sel,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] jal_base
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       iword_q, iword_d;
  logic              iword_valid_q, iword_valid_d;
  logic [ADDR_W-1:0] next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fault_q, fault_d;
`endif

  sc_next_pc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_next_pc (
    .pc       (pc_q),
    .pc_sel   (pc_sel),
    .imm      (imm),
    .jal_base (jal_base),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    iword_d       = iword_q;
    iword_valid_d = iword_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif
    case (state_q)
      FETCH_REQ: begin
        if (imem_req_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rsp_valid) begin
          iword_d       = imem_rsp_data;
          iword_valid_d = 1'b1;
          state_d       = FETCH_ISSUE;
        end
      end
      FETCH_ISSUE: begin
        if (retire) begin
          iword_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          pc_d = next_pc;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FETCH_FAULT;
          end else begin
            state_d = FETCH_REQ;
          end
`else
          // Without the trap, a misaligned target silently rounds down to a word boundary.
          pc_d    = next_pc & ~ADDR_W'(3);
          state_d = FETCH_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FETCH_FAULT: begin
        state_d = FETCH_FAULT;
      end
`endif
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_PC;
      iword_q       <= '0;
      iword_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      iword_q       <= iword_d;
      iword_valid_q <= iword_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= fault_d;
`endif
    end
  end

  // Request is gated by reset so nothing is issued while reset is held.
  assign imem_req_valid = reset_n && (state_q == FETCH_REQ);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign iword          = iword_q;
  assign iword_valid    = iword_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fetch_fault    = fault_q;
`endif

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Self-checking bench for sc_fetch_unit: table of fetch/retire vectors chained through
// the PC, plus hand sequences for spurious responses, reset in WAIT and misaligned JAL.
module tb_sc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] iword;
  logic        iword_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        retire;
  logic [1:0]  pc_sel;
  logic [15:0] imm;
  logic [31:0] jal_base;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  int nChecks = 0;
  int nFails  = 0;
  int acceptCount = 0;

  always #5 clk = ~clk;

  sc_fetch_unit #(
    .ADDR_W   (32),
    .IMM_W    (16),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .iword          (iword),
    .iword_valid    (iword_valid),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .retire         (retire),
    .pc_sel         (pc_sel),
    .imm            (imm),
    .jal_base       (jal_base)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always @(posedge clk) begin
    if (reset_n && imem_req_valid && imem_req_ready) acceptCount <= acceptCount + 1;
  end

  typedef struct {
    int          readyWait;
    int          rspWait;
    logic [31:0] data;
    logic [1:0]  sel;
    logic [15:0] immV;
    logic [31:0] base;
    logic [31:0] expPc;
    logic [31:0] expPc4;
    logic [31:0] expNext;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge with the DUT in REQ; returns at a negedge with the DUT in ISSUE.
  task automatic applyStimulus(input int readyWait, input int rspWait,
                               input logic [31:0] data, input logic [31:0] expAddr);
    int acc0;
    acc0 = acceptCount;
    imem_req_ready = 1'b0;
    for (int i = 0; i < readyWait; i++) begin
      checkOutput("stall req_valid", {31'b0, imem_req_valid}, 32'd1);
      checkOutput("stall imem_addr", imem_addr, expAddr);
      @(negedge clk);
    end
    checkOutput("req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("imem_addr", imem_addr, expAddr);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    checkOutput("req_valid after accept", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < rspWait; i++) begin
      checkOutput("iword_valid while waiting", {31'b0, iword_valid}, 32'd0);
      checkOutput("imem_addr while waiting", imem_addr, expAddr);
      @(negedge clk);
    end
    checkOutput("iword_valid before rsp", {31'b0, iword_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    checkOutput("iword_valid", {31'b0, iword_valid}, 32'd1);
    checkOutput("iword", iword, data);
    checkOutput("pc", pc, expAddr);
    checkOutput("accepted requests", acceptCount, acc0 + 1);
  endtask

  task automatic retireOne(input logic [1:0] sel, input logic [15:0] immV,
                           input logic [31:0] base, input logic [31:0] expNext);
    pc_sel   = sel;
    imm      = immV;
    jal_base = base;
    retire   = 1'b1;
    @(negedge clk);
    retire   = 1'b0;
    checkOutput("iword_valid after retire", {31'b0, iword_valid}, 32'd0);
    checkOutput("req_valid after retire", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("next imem_addr", imem_addr, expNext);
  endtask

  initial begin
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    retire         = 1'b0;
    pc_sel         = 2'd0;
    imm            = 16'h0;
    jal_base       = 32'h0;

    vecs[0] = '{0, 0, 32'h0000_0001, 2'd0, 16'h0000, 32'h0,         32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
    vecs[1] = '{0, 0, 32'h0000_0011, 2'd2, 16'h0000, 32'h0000_0040, 32'h0000_0004, 32'h0000_0008, 32'h0000_0040};
    vecs[2] = '{5, 3, 32'h0000_0022, 2'd1, 16'hFFFE, 32'h0,         32'h0000_0040, 32'h0000_0044, 32'h0000_003C};
    vecs[3] = '{0, 0, 32'h0000_0033, 2'd2, 16'h0000, 32'h0000_0100, 32'h0000_003C, 32'h0000_0040, 32'h0000_0100};
    vecs[4] = '{1, 1, 32'h0000_0044, 2'd2, 16'h0003, 32'h0000_2000, 32'h0000_0100, 32'h0000_0104, 32'h0000_200C};
    vecs[5] = '{0, 2, 32'h0000_0055, 2'd3, 16'h7FFF, 32'h0000_9999, 32'h0000_200C, 32'h0000_2010, 32'h0000_2010};
    vecs[6] = '{2, 0, 32'h0000_0066, 2'd1, 16'h0010, 32'h0,         32'h0000_2010, 32'h0000_2014, 32'h0000_2054};
    vecs[7] = '{0, 0, 32'h0000_0077, 2'd2, 16'h0003, 32'hFFFF_FFF0, 32'h0000_2054, 32'h0000_2058, 32'hFFFF_FFFC};
    vecs[8] = '{0, 0, 32'h0000_0088, 2'd0, 16'h0000, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{0, 0, 32'h0000_0099, 2'd1, 16'h8000, 32'h0,         32'h0000_0000, 32'h0000_0004, 32'hFFFE_0004};

    repeat (3) @(negedge clk);
    checkOutput("reset req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("reset pc", pc, 32'h0);
    checkOutput("reset iword", iword, 32'h0);
    checkOutput("reset iword_valid", {31'b0, iword_valid}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("reset fetch_fault", {31'b0, fetch_fault}, 32'd0);
`endif
    reset_n = 1'b1;
    #1;

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k].readyWait, vecs[k].rspWait, vecs[k].data, vecs[k].expPc);
      checkOutput("pc_plus4", pc_plus4, vecs[k].expPc4);
      retireOne(vecs[k].sel, vecs[k].immV, vecs[k].base, vecs[k].expNext);
    end

    // Response and retire while in REQ must both be ignored.
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_CAFE;
    retire         = 1'b1;
    pc_sel         = 2'd2;
    jal_base       = 32'h0000_0500;
    repeat (2) @(negedge clk);
    imem_rsp_valid = 1'b0;
    retire         = 1'b0;
    checkOutput("REQ ignores rsp/retire addr", imem_addr, 32'hFFFE_0004);
    checkOutput("REQ ignores rsp iword_valid", {31'b0, iword_valid}, 32'd0);
    checkOutput("REQ still requesting", {31'b0, imem_req_valid}, 32'd1);

    // Spurious response in ISSUE with retire low.
    applyStimulus(0, 0, 32'h0000_1234, 32'hFFFE_0004);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem_rsp_valid = 1'b0;
    checkOutput("ISSUE spurious iword", iword, 32'h0000_1234);
    checkOutput("ISSUE spurious iword_valid", {31'b0, iword_valid}, 32'd1);
    checkOutput("ISSUE spurious req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("ISSUE spurious pc", pc, 32'hFFFE_0004);
    retireOne(2'd0, 16'h0, 32'h0, 32'hFFFE_0008);

    // Reset pulsed while a request is outstanding, then a late response in REQ.
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    checkOutput("WAIT before reset req_valid", {31'b0, imem_req_valid}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset pc", pc, 32'h0);
    checkOutput("async reset iword_valid", {31'b0, iword_valid}, 32'd0);
    checkOutput("async reset req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0BAD;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    checkOutput("late rsp iword_valid", {31'b0, iword_valid}, 32'd0);
    checkOutput("late rsp req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("late rsp addr", imem_addr, 32'h0);

    // Misaligned JAL target.
    applyStimulus(0, 0, 32'h0000_0777, 32'h0);
    pc_sel   = 2'd2;
    imm      = 16'h0000;
    jal_base = 32'h0000_2001;
    retire   = 1'b1;
    @(negedge clk);
    retire   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("misaligned fetch_fault", {31'b0, fetch_fault}, 32'd1);
    checkOutput("misaligned pc", pc, 32'h0000_2001);
    begin
      int acc0;
      acc0 = acceptCount;
      imem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        checkOutput("FAULT req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("FAULT iword_valid", {31'b0, iword_valid}, 32'd0);
        @(negedge clk);
      end
      imem_req_ready = 1'b0;
      checkOutput("FAULT accepted requests", acceptCount, acc0);
      checkOutput("FAULT sticky", {31'b0, fetch_fault}, 32'd1);
    end
`else
    checkOutput("misaligned rounded addr", imem_addr, 32'h0000_2000);
    checkOutput("misaligned req_valid", {31'b0, imem_req_valid}, 32'd1);
    checkOutput("misaligned iword_valid", {31'b0, iword_valid}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
